// File: rtl/memwb_pkg.sv
// Shared types and constants for the MEM/WB pipeline register.
//   memwb_beat_t : captured write-back beat {wb_data, wr_reg, reg_write},
//                  laid out for the core's default 32-bit data / 5-bit index.
//   REG_ZERO     : index of the hard-wired $zero register.
package memwb_pkg;

  localparam int unsigned DATA_W_DEF     = 32'd32;
  localparam int unsigned REG_ADDR_W_DEF = 32'd5;
  localparam int unsigned REG_ZERO       = 32'd0;

  typedef struct packed {
    logic [DATA_W_DEF-1:0]     wb_data;
    logic [REG_ADDR_W_DEF-1:0] wr_reg;
    logic                      reg_write;
  } memwb_beat_t;

endpackage

// File: rtl/memwb_pipe_reg_if.sv
// Handshake and payload bus of the MEM/WB stage.
//   in_*  : beat offered by the MEM stage (valid/ready plus payload)
//   out_* : write-back beat presented to the WB consumer (valid/ready plus payload)
// master : the surrounding pipeline (drives in_* payload and out_ready)
// slave  : the pipeline register itself
interface memwb_pipe_reg_if #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_W-1:0]     in_read_data;
  logic [DATA_W-1:0]     in_alu_res;
  logic [REG_ADDR_W-1:0] in_wr_reg;
  logic                  in_mem_to_reg;
  logic                  in_reg_write;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_W-1:0]     out_wb_data;
  logic [REG_ADDR_W-1:0] out_wr_reg;
  logic                  out_reg_write;

  modport master (
    output in_valid, in_read_data, in_alu_res, in_wr_reg, in_mem_to_reg,
           in_reg_write, out_ready,
    input  in_ready, out_valid, out_wb_data, out_wr_reg, out_reg_write
  );

  modport slave (
    input  in_valid, in_read_data, in_alu_res, in_wr_reg, in_mem_to_reg,
           in_reg_write, out_ready,
    output in_ready, out_valid, out_wb_data, out_wr_reg, out_reg_write
  );
endinterface

// File: rtl/memwb_skid_buf.sv
// Generic two-entry skid buffer (main + skid register) with valid/ready and flush.
//   clk, rst_n          : clock, synchronous active-low reset
//   flush               : empties both entries at the next edge
//   in_valid/in_ready   : upstream handshake; in_ready is pure register state
//   in_data             : upstream payload
//   out_valid/out_ready : downstream handshake, out_data driven from the main register
module memwb_skid_buf #(
  parameter int WIDTH = 38
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             m_valid_r;
  logic [WIDTH-1:0] m_data_r;
  logic             s_valid_r;
  logic [WIDTH-1:0] s_data_r;
  logic             in_fire_s;

  // Ready depends only on skid occupancy, so out_ready never reaches in_ready.
  assign in_ready  = !s_valid_r;
  assign in_fire_s = in_valid && !s_valid_r;
  assign out_valid = m_valid_r;
  assign out_data  = m_data_r;

  // Main/skid storage: main refills from skid first so order is preserved.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_valid_r <= 1'b0;
      s_valid_r <= 1'b0;
      m_data_r  <= '0;
      s_data_r  <= '0;
    end else if (flush) begin
      m_valid_r <= 1'b0;
      s_valid_r <= 1'b0;
    end else if (!m_valid_r || out_ready) begin
      if (s_valid_r) begin
        m_data_r  <= s_data_r;
        m_valid_r <= 1'b1;
        s_valid_r <= 1'b0;
      end else if (in_fire_s) begin
        m_data_r  <= in_data;
        m_valid_r <= 1'b1;
      end else begin
        m_valid_r <= 1'b0;
      end
    end else if (in_fire_s) begin
      // Main is stalled: the beat accepted this cycle parks in the skid entry.
      s_data_r  <= in_data;
      s_valid_r <= 1'b1;
    end
  end

endmodule

// File: rtl/memwb_pipe_reg.sv
// MEM/WB pipeline register of the five-stage MIPS core.
//   clk, rst_n    : clock, synchronous active-low reset
//   bus (slave)   : MEM-side valid/ready + payload in, WB-side valid/ready + beat out
//   flush         : drops held beats and any beat offered in the same cycle
//   fwd_valid/reg/data : forwarding candidate for the hazard unit
//   stall_cnt     : saturating count of cycles with out_valid && !out_ready
// Build option: define MEMWB_SKID_EN for two-entry storage with a registered
// in_ready; otherwise a single register with in_ready = out_ready || !out_valid.
module memwb_pipe_reg
  import memwb_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  memwb_pipe_reg_if.slave       bus,
  input  logic                  flush,
  output logic                  fwd_valid,
  output logic [REG_ADDR_W-1:0] fwd_reg,
  output logic [DATA_W-1:0]     fwd_data,
  output logic [CNT_W-1:0]      stall_cnt
);

  // Same field layout as memwb_beat_t, sized from this instance's parameters.
  typedef struct packed {
    logic [DATA_W-1:0]     wb_data;
    logic [REG_ADDR_W-1:0] wr_reg;
    logic                  reg_write;
  } beat_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  beat_t            in_beat_s;
  beat_t            out_beat_s;
  logic             out_valid_s;
  logic             in_ready_s;
  logic [CNT_W-1:0] stall_cnt_r;

  // Resolve the write-back select and $zero qualification before capture.
  always_comb begin
    in_beat_s           = '0;
    in_beat_s.wb_data   = bus.in_mem_to_reg ? bus.in_read_data : bus.in_alu_res;
    in_beat_s.wr_reg    = bus.in_wr_reg;
    in_beat_s.reg_write = bus.in_reg_write && (bus.in_wr_reg != REG_ADDR_W'(REG_ZERO));
  end

`ifdef MEMWB_SKID_EN
  memwb_skid_buf #(
    .WIDTH ($bits(beat_t))
  ) u_skid_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (bus.in_valid),
    .in_ready  (in_ready_s),
    .in_data   (in_beat_s),
    .out_valid (out_valid_s),
    .out_ready (bus.out_ready),
    .out_data  (out_beat_s)
  );
`else
  logic  out_valid_r;
  beat_t out_beat_r;

  assign in_ready_s  = bus.out_ready || !out_valid_r;
  assign out_valid_s = out_valid_r;
  assign out_beat_s  = out_beat_r;

  // Single output register: load on accept, empty on pop, hold while stalled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_beat_r  <= '0;
    end else if (flush) begin
      out_valid_r <= 1'b0;
    end else if (bus.in_valid && in_ready_s) begin
      out_valid_r <= 1'b1;
      out_beat_r  <= in_beat_s;
    end else if (bus.out_ready) begin
      out_valid_r <= 1'b0;
    end
  end
`endif

  // in_ready is forced high while in reset, where inputs are ignored anyway.
  assign bus.in_ready      = in_ready_s || !rst_n;
  assign bus.out_valid     = out_valid_s;
  assign bus.out_wb_data   = out_beat_s.wb_data;
  assign bus.out_wr_reg    = out_beat_s.wr_reg;
  assign bus.out_reg_write = out_beat_s.reg_write;

  assign fwd_valid = out_valid_s && out_beat_s.reg_write;
  assign fwd_reg   = out_beat_s.wr_reg;
  assign fwd_data  = out_beat_s.wb_data;
  assign stall_cnt = stall_cnt_r;

  // Stall counter: saturates, survives flush, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_r <= '0;
    end else if (out_valid_s && !bus.out_ready && (stall_cnt_r != CNT_MAX)) begin
      stall_cnt_r <= stall_cnt_r + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_memwb_pipe_reg.sv
// Self-checking bench for memwb_pipe_reg: directed steps plus random traffic,
// compared every cycle against a beat-queue reference model.
module tb_memwb_pipe_reg;
  import memwb_pkg::*;

  localparam int CNT_W = 4;
  localparam int unsigned CNT_MAX = (32'd1 << CNT_W) - 32'd1;
`ifdef MEMWB_SKID_EN
  localparam int EXTRA_ACC = 1;
`else
  localparam int EXTRA_ACC = 0;
`endif

  logic             clk;
  logic             rst_n;
  logic             flush;
  logic             fwd_valid;
  logic [4:0]       fwd_reg;
  logic [31:0]      fwd_data;
  logic [CNT_W-1:0] stall_cnt;

  memwb_pipe_reg_if #(.DATA_W(32), .REG_ADDR_W(5)) bus ();

  memwb_pipe_reg #(.DATA_W(32), .REG_ADDR_W(5), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .flush     (flush),
    .fwd_valid (fwd_valid),
    .fwd_reg   (fwd_reg),
    .fwd_data  (fwd_data),
    .stall_cnt (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  memwb_beat_t q[$];
  int unsigned cnt_m;
  int          n_tests;
  int          n_fail;
  int          acc_obs;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_outs();
    chk("out_valid", 64'(bus.out_valid), 64'(q.size() > 0));
    if (q.size() > 0) begin
      chk("out_wb_data", 64'(bus.out_wb_data), 64'(q[0].wb_data));
      chk("out_wr_reg", 64'(bus.out_wr_reg), 64'(q[0].wr_reg));
      chk("out_reg_write", 64'(bus.out_reg_write), 64'(q[0].reg_write));
      chk("fwd_valid", 64'(fwd_valid), 64'(q[0].reg_write));
      chk("fwd_reg", 64'(fwd_reg), 64'(q[0].wr_reg));
      chk("fwd_data", 64'(fwd_data), 64'(q[0].wb_data));
    end else begin
      chk("fwd_valid_idle", 64'(fwd_valid), 64'd0);
    end
    chk("stall_cnt", 64'(stall_cnt), 64'(cnt_m));
  endtask

  // One clock cycle: drive at negedge, check in_ready, update model at posedge, check outputs.
  task automatic step(input logic iv, input logic [31:0] rd, input logic [31:0] alu,
                      input logic [4:0] wr, input logic m2r, input logic rw,
                      input logic ordy, input logic fl);
    logic        exp_rdy;
    memwb_beat_t b;
    @(negedge clk);
    bus.in_valid      = iv;
    bus.in_read_data  = rd;
    bus.in_alu_res    = alu;
    bus.in_wr_reg     = wr;
    bus.in_mem_to_reg = m2r;
    bus.in_reg_write  = rw;
    bus.out_ready     = ordy;
    flush             = fl;
    #1;
`ifdef MEMWB_SKID_EN
    exp_rdy = !rst_n || (q.size() < 2);
`else
    exp_rdy = !rst_n || ordy || (q.size() == 0);
`endif
    chk("in_ready", 64'(bus.in_ready), 64'(exp_rdy));
    if (rst_n && iv && bus.in_ready) acc_obs++;
    @(posedge clk);
    if (!rst_n) begin
      q.delete();
      cnt_m = 0;
    end else begin
      if (q.size() > 0 && !ordy && cnt_m < CNT_MAX) cnt_m++;
      if (fl) begin
        q.delete();
      end else begin
        if (q.size() > 0 && ordy) void'(q.pop_front());
        if (iv && exp_rdy) begin
          b.wb_data   = m2r ? rd : alu;
          b.wr_reg    = wr;
          b.reg_write = rw && (wr != 5'd0);
          q.push_back(b);
        end
      end
    end
    #1;
    check_outs();
  endtask

  initial begin
    int unsigned saved;
    n_tests = 0;
    n_fail  = 0;
    cnt_m   = 0;
    acc_obs = 0;
    rst_n   = 1'b0;
    flush   = 1'b0;
    bus.in_valid = 1'b0; bus.in_read_data = 32'd0; bus.in_alu_res = 32'd0;
    bus.in_wr_reg = 5'd0; bus.in_mem_to_reg = 1'b0; bus.in_reg_write = 1'b0;
    bus.out_ready = 1'b0;

    // Reset held 3 cycles with a beat offered.
    for (int i = 0; i < 3; i++) step(1'b1, 32'hAAAA_0000, 32'h5555_0000, 5'd3, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_wb_data", 64'(bus.out_wb_data), 64'd0);
    chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);
    rst_n = 1'b1;

    // Streaming, one-cycle latency.
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 32'hFFFF_FFFF, 32'h10 + 32'(i), 5'd4, 1'b0, 1'b1, 1'b1, 1'b0);
      chk("stream_data", 64'(bus.out_wb_data), 64'(32'h10 + 32'(i)));
    end
    step(1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Write-back select and $zero qualification.
    step(1'b1, 32'hDEAD_BEEF, 32'h1234_5678, 5'd8, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("sel_data", 64'(bus.out_wb_data), 64'h0000_0000_DEAD_BEEF);
    chk("sel_reg_write", 64'(bus.out_reg_write), 64'd1);
    chk("sel_fwd_valid", 64'(fwd_valid), 64'd1);
    chk("sel_fwd_reg", 64'(fwd_reg), 64'd8);
    step(1'b1, 32'hDEAD_BEEF, 32'h1234_5678, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("zero_reg_write", 64'(bus.out_reg_write), 64'd0);
    chk("zero_fwd_valid", 64'(fwd_valid), 64'd0);

    // Back-pressure for 5 cycles while streaming.
    step(1'b1, 32'd0, 32'h100, 5'd9, 1'b0, 1'b1, 1'b1, 1'b0);
    acc_obs = 0;
    for (int i = 0; i < 5; i++) step(1'b1, 32'd0, 32'h200 + 32'(i), 5'd9, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("bp_stall_cnt", 64'(stall_cnt), 64'd5);
    chk("bp_extra_accept", 64'(acc_obs), 64'(EXTRA_ACC));
    for (int i = 0; i < 3; i++) step(1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Flush with one beat held and an input beat offered.
    step(1'b1, 32'd0, 32'h300, 5'd10, 1'b0, 1'b1, 1'b1, 1'b0);
    saved = cnt_m;
    step(1'b1, 32'd0, 32'h301, 5'd10, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("flush_out_valid", 64'(bus.out_valid), 64'd0);
    chk("flush_stall_cnt", 64'(stall_cnt), 64'(saved));
    // Flush with storage filled under stall, then confirm nothing re-emerges.
    step(1'b1, 32'd0, 32'h400, 5'd11, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'd0, 32'h401, 5'd11, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'd0, 32'h402, 5'd11, 1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("flush_skid_empty", 64'(bus.out_valid), 64'd0);

    // Random traffic against the model.
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 1)), $urandom, $urandom, 5'($urandom_range(0, 31)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 19) == 0));
    end

    // Saturation: stall 20 cycles with a 4-bit counter.
    rst_n = 1'b0;
    step(1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    rst_n = 1'b1;
    step(1'b1, 32'd0, 32'h500, 5'd12, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("sat_stall_cnt", 64'(stall_cnt), 64'd15);

    // Reset mid-stall.
    rst_n = 1'b0;
    step(1'b1, 32'd0, 32'h600, 5'd13, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("rst_mid_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_mid_stall_cnt", 64'(stall_cnt), 64'd0);
    rst_n = 1'b1;
    step(1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
